// File: rtl/user_rom_pkg.sv
// Shared types for the user-domain ROM bank: FSM states, response-pipeline stage,
// default OBI request/response structs and the checksum step function.
package user_rom_pkg;

  typedef enum logic [0:0] {SCAN, READY} rom_state_e;

  localparam int unsigned MaxReadLatency = 4;
  localparam int unsigned MaxIdWidth     = 16;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } user_rom_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } user_rom_obi_rsp_t;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
    logic [31:0]           data;
    logic                  err;
  } rsp_stage_t;

  // Signature step: rotate left by one, then fold in the next word.
  function automatic logic [31:0] rom_sig_step(input logic [31:0] acc, input logic [31:0] word);
    return {acc[30:0], acc[31]} ^ word;
  endfunction

endpackage

// File: rtl/user_rom_rsp_pipe.sv
// Fixed-latency response shift register; stage_o is the response Depth cycles after
// stage_i was captured. No backpressure, so it can never overflow.
module user_rom_rsp_pipe
  import user_rom_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rsp_stage_t stage_i,
  output rsp_stage_t stage_o
);

  rsp_stage_t r_stages [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_stages[i] <= '0;
      end
    end else begin
      r_stages[0] <= stage_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        r_stages[i] <= r_stages[i-1];
      end
    end
  end

  assign stage_o = r_stages[Depth-1];

endmodule

// File: rtl/user_rom_bank.sv
// Parametrised OBI read-only memory. Define USER_ROM_BANK_CHECKSUM_EN to add the boot-time
// checksum scan and the status word at offset RegionBytes-4.
module user_rom_bank
  import user_rom_pkg::*;
#(
  parameter obi_cfg_t                  ObiCfg      = ObiDefaultConfig,
  parameter type                       obi_req_t   = user_rom_obi_req_t,
  parameter type                       obi_rsp_t   = user_rom_obi_rsp_t,
  parameter int unsigned               NumWords    = 16,
  parameter int unsigned               RegionBytes = 4096,
  parameter int unsigned               ReadLatency = 1,
  parameter logic [NumWords-1:0][31:0] RomData     = '0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic        scan_done_o,
  output logic [31:0] checksum_o
);

  localparam int unsigned OffW      = $clog2(RegionBytes);
  localparam int unsigned IdxW      = OffW - 2;
  localparam int unsigned IdW       = ObiCfg.IdWidth;
  localparam int unsigned PipeDepth = (ReadLatency < 1) ? 1 :
                                      (ReadLatency > MaxReadLatency) ? MaxReadLatency :
                                      ReadLatency;

  rom_state_e      w_state;
  logic [31:0]     w_checksum;
  logic            w_gnt;
  logic [IdxW-1:0] w_index;
  rsp_stage_t      w_stage_in;
  rsp_stage_t      w_stage_out;
  logic            w_unused;

  // Byte lanes, write data and sub-word address bits never affect a ROM response.
  assign w_unused = ^{obi_req_i.a.addr, obi_req_i.a.be, obi_req_i.a.wdata,
                      obi_req_i.a.a_optional};

`ifdef USER_ROM_BANK_CHECKSUM_EN
  localparam int unsigned     CntW      = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [IdxW-1:0] StatusIdx = IdxW'(RegionBytes / 4 - 1);

  rom_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [31:0]     r_acc, w_acc_d;
  logic [31:0]     w_scan_word;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SCAN;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_acc   <= w_acc_d;
    end
  end

  always_comb begin
    w_scan_word = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      if (r_cnt == CntW'(i)) w_scan_word = RomData[i];
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_acc_d   = r_acc;
    case (r_state)
      SCAN: begin
        w_acc_d = rom_sig_step(r_acc, w_scan_word);
        w_cnt_d = r_cnt + CntW'(1);
        if (r_cnt == CntW'(NumWords - 1)) w_state_d = READY;
      end
      default: w_state_d = READY;
    endcase
  end

  assign w_state    = r_state;
  assign w_checksum = (r_state == READY) ? r_acc : '0;
`else
  assign w_state    = READY;
  assign w_checksum = '0;
`endif

  assign w_gnt   = obi_req_i.req && (w_state == READY);
  assign w_index = obi_req_i.a.addr[OffW-1:2];

  always_comb begin
    w_stage_in = '0;
    if (w_gnt) begin
      w_stage_in.valid = 1'b1;
      w_stage_in.id    = MaxIdWidth'(obi_req_i.a.aid);
      w_stage_in.err   = 1'b1;
      if (!obi_req_i.a.we) begin
        for (int unsigned i = 0; i < NumWords; i++) begin
          if (w_index == IdxW'(i)) begin
            w_stage_in.data = RomData[i];
            w_stage_in.err  = 1'b0;
          end
        end
`ifdef USER_ROM_BANK_CHECKSUM_EN
        if (w_index == StatusIdx) begin
          w_stage_in.data = w_checksum;
          w_stage_in.err  = 1'b0;
        end
`endif
      end
    end
  end

  user_rom_rsp_pipe #(
    .Depth (PipeDepth)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stage_i (w_stage_in),
    .stage_o (w_stage_out)
  );

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = w_gnt;
    obi_rsp_o.rvalid       = w_stage_out.valid;
    obi_rsp_o.r.rdata      = w_stage_out.data;
    obi_rsp_o.r.err        = w_stage_out.err;
    obi_rsp_o.r.rid        = IdW'(w_stage_out.id);
    obi_rsp_o.r.r_optional = 1'b0;
  end

  assign scan_done_o = (w_state == READY);
  assign checksum_o  = w_checksum;

endmodule

// File: tb/tb_user_rom_bank.sv
// Self-checking bench for user_rom_bank: behavioural response/scan model checked every cycle,
// plus directed literal checks, under randomized OBI traffic and resets.
module tb_user_rom_bank;
  import user_rom_pkg::*;

  localparam int unsigned NW = 4;
  localparam int unsigned L  = 3;
`ifdef USER_ROM_BANK_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    logic [3:0]  id;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  user_rom_obi_req_t req;
  user_rom_obi_rsp_t rsp;
  logic              scan_done;
  logic [31:0]       checksum;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pc       = 0;
  int          rdy_cnt  = 0;
  logic [31:0] rom [NW];
  logic [31:0] m_sig;
  exp_t        q [$];
  logic [31:0] lg_data [$];
  logic [3:0]  lg_id [$];
  logic        lg_err [$];

  always #5 clk = ~clk;

  user_rom_bank #(
    .NumWords    (NW),
    .RegionBytes (4096),
    .ReadLatency (L),
    .RomData     ({32'h0000_1000, 32'h0000_0100, 32'h0000_0010, 32'h0000_0001})
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi_req_i   (req),
    .obi_rsp_o   (rsp),
    .scan_done_o (scan_done),
    .checksum_o  (checksum)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void exp_rsp(input logic we, input logic [31:0] addr,
                                  output logic [31:0] d, output logic e);
    int unsigned idx;
    idx = (addr % 4096) / 4;
    d = 32'h0;
    e = 1'b1;
    if (!we) begin
      if (idx < NW) begin
        d = rom[idx];
        e = 1'b0;
      end else if (CK && idx == 1023) begin
        d = m_sig;
        e = 1'b0;
      end
    end
  endfunction

  // Per-cycle compare against the model, then predict what the next clock edge accepts.
  initial begin
    logic m_ready;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        rdy_cnt = 0;
        chk("rst_rvalid", {31'b0, rsp.rvalid}, 32'h0);
        chk("rst_rdata", rsp.r.rdata, 32'h0);
        chk("rst_err", {31'b0, rsp.r.err}, 32'h0);
        chk("rst_rid", {28'b0, rsp.r.rid}, 32'h0);
        chk("rst_gnt", {31'b0, rsp.gnt}, {31'b0, CK ? 1'b0 : req.req});
        chk("rst_scan_done", {31'b0, scan_done}, {31'b0, !CK});
        chk("rst_checksum", checksum, 32'h0);
      end else begin
        m_ready = !CK || (rdy_cnt >= NW);
        chk("gnt", {31'b0, rsp.gnt}, {31'b0, req.req && m_ready});
        chk("scan_done", {31'b0, scan_done}, {31'b0, m_ready});
        chk("checksum", checksum, (m_ready && CK) ? m_sig : 32'h0);
        chk("r_optional", {31'b0, rsp.r.r_optional}, 32'h0);
        if (q.size() > 0 && q[0].due == pc) begin
          e = q.pop_front();
          chk("rvalid", {31'b0, rsp.rvalid}, 32'h1);
          chk("rdata", rsp.r.rdata, e.data);
          chk("err", {31'b0, rsp.r.err}, {31'b0, e.err});
          chk("rid", {28'b0, rsp.r.rid}, {28'b0, e.id});
          lg_data.push_back(rsp.r.rdata);
          lg_id.push_back(rsp.r.rid);
          lg_err.push_back(rsp.r.err);
        end else begin
          chk("rvalid_idle", {31'b0, rsp.rvalid}, 32'h0);
        end
        if (req.req && m_ready) begin
          exp_rsp(req.a.we, req.a.addr, e.data, e.err);
          e.id  = req.a.aid;
          e.due = pc + L;
          q.push_back(e);
        end
        pc++;
        if (rdy_cnt < NW) rdy_cnt++;
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] id);
    req.req          = r;
    req.a.we         = w;
    req.a.addr       = a;
    req.a.aid        = id;
    req.a.be         = 4'($urandom);
    req.a.wdata      = $urandom;
    req.a.a_optional = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  initial begin
    int cyc;
    int n0;
    int sz;
    rom[0] = 32'h0000_0001;
    rom[1] = 32'h0000_0010;
    rom[2] = 32'h0000_0100;
    rom[3] = 32'h0000_1000;
    m_sig = 32'h0;
    for (int i = 0; i < NW; i++) m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ rom[i];
    chk("model_sig", m_sig, 32'h0000_1248);

    rst_n = 1'b0;
    req   = '0;
    // Request held from reset onward: must be granted on the first READY cycle.
    req.req    = 1'b1;
    req.a.addr = 32'h4;
    req.a.aid  = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (rsp.gnt) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("held_gnt_cycle", cyc, CK ? 32'd4 : 32'd0);
    @(posedge clk);
    #1;
    chk("checksum_lit", checksum, CK ? 32'h0000_1248 : 32'h0);
    chk("scan_done_lit", {31'b0, scan_done}, 32'h1);
    idle(L + 2);
    sz = lg_data.size();
    chk("held_rdata", lg_data[sz-1], 32'h10);
    chk("held_rid", {28'b0, lg_id[sz-1]}, 32'd5);

    drive(1'b1, 1'b0, 32'h0, 4'd1);
    drive(1'b1, 1'b0, 32'h4, 4'd2);
    drive(1'b1, 1'b0, 32'hC, 4'd3);
    idle(L + 2);
    sz = lg_data.size();
    chk("b2b_d0", lg_data[sz-3], 32'h1);
    chk("b2b_d1", lg_data[sz-2], 32'h10);
    chk("b2b_d2", lg_data[sz-1], 32'h1000);
    chk("b2b_ids", {20'b0, lg_id[sz-3], lg_id[sz-2], lg_id[sz-1]}, 32'h123);

    drive(1'b1, 1'b0, 32'h10, 4'd6);
    drive(1'b1, 1'b1, 32'h0, 4'd7);
    drive(1'b1, 1'b0, 32'h0, 4'd8);
    drive(1'b1, 1'b0, 32'hFFC, 4'd9);
    idle(L + 2);
    sz = lg_data.size();
    chk("oor_rsp", {lg_data[sz-4][30:0], lg_err[sz-4]}, 32'h1);
    chk("wr_err", {31'b0, lg_err[sz-3]}, 32'h1);
    chk("rd_after_wr", lg_data[sz-2], 32'h1);
    chk("status_rdata", lg_data[sz-1], CK ? 32'h0000_1248 : 32'h0);
    chk("status_err", {31'b0, lg_err[sz-1]}, {31'b0, !CK});

    // Reset with a read in flight: its response must never appear.
    n0 = lg_data.size();
    drive(1'b1, 1'b0, 32'h0, 4'd10);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (scan_done) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rescan_cycles", cyc, CK ? 32'd4 : 32'd0);
    @(posedge clk);
    #1;
    idle(L + 2);
    chk("flush_no_rsp", lg_data.size(), n0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom % 4)
        0: a = ($urandom % 6) * 4 + ($urandom % 4);
        1: a = {$urandom, 12'h0} | 32'hFFC;
        2: a = $urandom;
        default: a = ($urandom % 4) * 4;
      endcase
      if ($urandom % 100 == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      drive(($urandom % 10) < 7, ($urandom % 5) == 0, a, 4'($urandom));
    end
    rst_n = 1'b1;
    idle(NW + L + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/user_rom_bank.md
# user_rom_bank

Parametrised read-only memory for the user domain, attached as an OBI subordinate behind the user-domain address decoder. Contents, depth, region size and read latency are set by parameters. Writes and out-of-range reads return error responses. An optional boot-time checksum scan walks the whole ROM after reset and publishes a signature to software and to the top level.

## Interface
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration: AddrWidth, DataWidth = 32, IdWidth.
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- NumWords, 16, number of 32-bit ROM words; range 1..1023.
- RegionBytes, 4096, decoded region size in bytes; power of two; NumWords*4 <= RegionBytes-4.
- ReadLatency, 1, cycles from grant to rvalid; range 1..4.
- RomData, '0, logic [NumWords-1:0][31:0], word contents; index 0 is at offset 0.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- obi_req_i  in  obi_req_t  OBI request.
- obi_rsp_o  out  obi_rsp_t  OBI response.
- scan_done_o  out  1  checksum valid.
- checksum_o  out  32  ROM signature.

## Operation
- Offset = addr[log2(RegionBytes)-1:0]. Word index = offset >> 2. addr[1:0] and be are ignored.
- Read with index < NumWords: rdata = RomData[index], err = 0.
- Read with index >= NumWords, other than the status word: rdata = 0, err = 1.
- Any write: rdata = 0, err = 1. The ROM is never modified.
- rid = aid of the originating request. r_optional = 0.
- Requests are granted combinationally (gnt = req) when the FSM is in READY. A new request can be accepted every cycle.
- The response pipeline has a fixed depth of ReadLatency and no backpressure, so it cannot overflow. Responses stay in request order.
- FSM states: SCAN (reset state when the checksum is compiled in) and READY.
  - SCAN: gnt = 0. A scan counter walks 0..NumWords-1, one word per cycle.
  - Accumulator update: acc = rotl(acc, 1) ^ RomData[cnt], with acc starting at 0.
  - After the last word: go to READY, set scan_done_o = 1, and hold checksum_o = acc.
  - READY: normal service. This state is absorbing until reset.
- Status word at offset RegionBytes-4 (checksum build only): a read returns checksum_o, err = 0.
- Reset values: gnt 0 while in SCAN, rvalid 0, rdata 0, err 0, rid 0, scan_done_o 0, checksum_o 0. All pipeline stages are cleared.
- Reset asserted mid-scan or mid-response: pipeline contents are discarded and the scan restarts from index 0. No stale rvalid appears after reset release.
- A request held during SCAN is not granted; it is granted on the first READY cycle.

## Timing
- Handshake at edge t (req & gnt): rvalid is high in cycle t+ReadLatency, together with rdata, err and rid.
- Back-to-back grants produce back-to-back rvalid cycles.
- Scan duration is exactly NumWords cycles after reset release. gnt can first be high in cycle NumWords.
- scan_done_o rises in the same cycle the FSM enters READY.
- Without the checksum feature: gnt = req from the first cycle after reset release.

## Configuration
- Macro: USER_ROM_BANK_CHECKSUM_EN.
- Defined: SCAN state, scan counter, accumulator and status word are present.
- Undefined:
  - The FSM is fixed in READY.
  - scan_done_o is tied to 1 and checksum_o to 0.
  - Offset RegionBytes-4 decodes as out-of-range (err = 1).
  - No scan logic is synthesised.

## Structure
- Package user_rom_pkg:
  - state enum rom_state_e {SCAN, READY}.
  - constant MaxReadLatency = 4.
  - function rom_sig_step(acc, word), implementing rotl-1 then XOR.
  - response-stage struct {valid, id, data, err}.
- Sub-module user_rom_rsp_pipe: parametrised fixed-latency shift register of response-stage structs with asynchronous reset. It is used for all ReadLatency values.

## Test plan
Default configuration for all scenarios: NumWords = 4, RomData = {1, 1, 1, 1}, RegionBytes = 4096.
- Reset then wait, checksum build: scan_done_o rises at cycle 4. checksum_o = 0x0000000F. gnt is 0 in cycles 0..3.
- ReadLatency = 3: reads at offsets 0x0, 0x4, 0xC in consecutive cycles with aid 1, 2, 3. rvalid appears 3 cycles after each grant, rdata = 1, err = 0, rid = 1, 2, 3 in order.
- Read at offset 0x10 -> rdata 0, err 1. Write at offset 0x0 -> err 1. A following read at 0x0 still returns 1.
- Read at offset 0xFFC: checksum build returns 0x0000000F with err 0. Build without the macro returns rdata 0 with err 1.
- Assert rst_ni at scan cycle 2 and with a read in flight: the in-flight response never appears. The scan restarts, and scan_done_o rises 4 cycles after release.
- Request held high during SCAN: granted exactly on the first READY cycle, response ReadLatency cycles later.
